mux_4way_16: RTL and testbench
==============================

// Module: mux_4way_16
// PURPOSE
//  Four-input, WIDTH-bit word selector for datapath operand steering.
//  s picks one of W/X/Y/Z and drives it on OUT combinationally (zero latency).
//  A registered copy (OUT_Q, S_Q, VLD_Q) is provided for timing-critical consumers.
//  One clock; reset is synchronous and active-low.
// PARAMETERS
//  WIDTH     16   data width of W, X, Y, Z, OUT, OUT_Q
//  RST_VAL   0    value loaded into OUT_Q on reset (WIDTH bits)
// PORTS
//  clk    in   1      rising-edge clock
//  rst_n  in   1      synchronous active-low reset
//  W      in   WIDTH  data input 0
//  X      in   WIDTH  data input 1
//  Y      in   WIDTH  data input 2
//  Z      in   WIDTH  data input 3
//  s      in   2      select: 00=W, 01=X, 10=Y, 11=Z
//  en     in   1      capture enable for registered path
//  OUT    out  WIDTH  combinational selected word
//  OUT_Q  out  WIDTH  registered selected word
//  S_Q    out  2      select value captured with OUT_Q
//  VLD_Q  out  1      OUT_Q holds a word captured since reset
// BEHAVIOUR
//  - OUT = (s==0)?W : (s==1)?X : (s==2)?Y : Z. Pure combinational; no clock or
//    reset dependency; updates in the same delta as any input change.
//  - All four s codes are legal; there is no default/X output.
//  - OUT is never latched; no inference of storage on the combinational path.
//  - Full-width pass-through: no truncation, extension or arithmetic on data.
//  - Registered path, on posedge clk:
//      rst_n==0           -> OUT_Q<=RST_VAL, S_Q<=0, VLD_Q<=0 (overrides en)
//      rst_n==1 && en==1  -> OUT_Q<=OUT, S_Q<=s, VLD_Q<=1
//      rst_n==1 && en==0  -> hold all three
//  - Latency: OUT 0 cycles; OUT_Q/S_Q/VLD_Q 1 cycle after an enabled edge.
//  - Reset mid-operation: the next edge clears the registers regardless of en;
//    OUT keeps tracking inputs throughout reset.
//  - Simultaneous s and data change: OUT reflects the new s with the new data;
//    OUT_Q captures the values present at the clock edge.
//  - Before the first clock edge the register outputs are undefined; only OUT is valid.
// TESTING
//  1. W=X=Y=Z=0, s=0 -> OUT=0.
//  2. W=11,X=2,Y=24,Z=8, s=1 -> OUT=2; then s=0 -> 11, s=2 -> 24, s=3 -> 8.
//  3. W=22,X=4,Y=48,Z=16, s=2 -> OUT=48; W=44,X=8,Y=96,Z=32, s=0 -> OUT=44.
//  4. W=16'hFFFF,X=0,Y=16'hA5A5,Z=16'h5A5A, sweep s=0..3 -> OUT=FFFF,0000,A5A5,5A5A.
//  5. rst_n=0 one edge -> OUT_Q=0, S_Q=0, VLD_Q=0; en=1, s=3, Z=24,
//     edge -> OUT_Q=24, S_Q=3, VLD_Q=1.
//  6. en=0, change s and data, clock 3 edges -> OUT_Q/S_Q held; OUT follows.
//     Then rst_n=0 with en=1 -> cleared.

Source files
------------

// File: rtl/mux_4way_16.sv
// mux_4way_16: 4-input word selector with a combinational output and an enabled registered copy
module mux_4way_16 #(
    parameter int               WIDTH   = 16,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] W,
    input  logic [WIDTH-1:0] X,
    input  logic [WIDTH-1:0] Y,
    input  logic [WIDTH-1:0] Z,
    input  logic [1:0]       s,
    input  logic             en,
    output logic [WIDTH-1:0] OUT,
    output logic [WIDTH-1:0] OUT_Q,
    output logic [1:0]       S_Q,
    output logic             VLD_Q
);
    logic [WIDTH-1:0] w_sel;
    logic [WIDTH-1:0] r_out_q;
    logic [1:0]       r_s_q;
    logic             r_vld_q;
    // select one of the four words; every select code maps to an input, so no storage is inferred
    always_comb w_sel = (s == 2'd0) ? W : (s == 2'd1) ? X : (s == 2'd2) ? Y : Z;
    // capture the selected word and its select code on enabled edges; reset wins over enable
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_out_q <= RST_VAL;
            r_s_q   <= 2'd0;
            r_vld_q <= 1'b0;
        end else if (en) begin
            r_out_q <= w_sel;
            r_s_q   <= s;
            r_vld_q <= 1'b1;
        end
    end
    assign OUT   = w_sel;
    assign OUT_Q = r_out_q;
    assign S_Q   = r_s_q;
    assign VLD_Q = r_vld_q;
endmodule

// File: tb/tb_mux_4way_16.sv
// tb_mux_4way_16: directed and random checks of the combinational and registered select paths
module tb_mux_4way_16;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] W = '0, X = '0, Y = '0, Z = '0;
    logic [1:0]  s = '0;
    logic        en = 1'b0;
    logic [15:0] OUT, OUT_Q;
    logic [1:0]  S_Q;
    logic        VLD_Q;
    int n_checks = 0;
    int n_fail = 0;
    logic [15:0] m_q;
    logic [1:0]  m_s;
    logic        m_v;

    mux_4way_16 #(.WIDTH(16), .RST_VAL(16'h0000)) dut (
        .clk(clk), .rst_n(rst_n), .W(W), .X(X), .Y(Y), .Z(Z), .s(s), .en(en),
        .OUT(OUT), .OUT_Q(OUT_Q), .S_Q(S_Q), .VLD_Q(VLD_Q)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] ref_out();
        logic [15:0] words [4];
        words = '{W, X, Y, Z};
        return words[s];
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic set_in(input logic [15:0] w, x, y, z, input logic [1:0] sel);
        W = w; X = x; Y = y; Z = z; s = sel;
        #1;
        chk("OUT", {16'h0, OUT}, {16'h0, ref_out()});
    endtask

    task automatic tick();
        if (!rst_n) begin
            m_q = 16'h0; m_s = 2'd0; m_v = 1'b0;
        end else if (en) begin
            m_q = ref_out(); m_s = s; m_v = 1'b1;
        end
        @(posedge clk);
        #1;
        chk("OUT_Q", {16'h0, OUT_Q}, {16'h0, m_q});
        chk("S_Q", {30'h0, S_Q}, {30'h0, m_s});
        chk("VLD_Q", {31'h0, VLD_Q}, {31'h0, m_v});
        chk("OUT_clk", {16'h0, OUT}, {16'h0, ref_out()});
    endtask

    initial begin
        set_in(16'd0, 16'd0, 16'd0, 16'd0, 2'd0);
        chk("t1_const", {16'h0, OUT}, 32'd0);
        set_in(16'd11, 16'd2, 16'd24, 16'd8, 2'd1);
        chk("t2_s1", {16'h0, OUT}, 32'd2);
        set_in(16'd11, 16'd2, 16'd24, 16'd8, 2'd0);
        chk("t2_s0", {16'h0, OUT}, 32'd11);
        set_in(16'd11, 16'd2, 16'd24, 16'd8, 2'd2);
        chk("t2_s2", {16'h0, OUT}, 32'd24);
        set_in(16'd11, 16'd2, 16'd24, 16'd8, 2'd3);
        chk("t2_s3", {16'h0, OUT}, 32'd8);
        set_in(16'd22, 16'd4, 16'd48, 16'd16, 2'd2);
        chk("t3_a", {16'h0, OUT}, 32'd48);
        set_in(16'd44, 16'd8, 16'd96, 16'd32, 2'd0);
        chk("t3_b", {16'h0, OUT}, 32'd44);
        for (int i = 0; i < 4; i++) begin
            set_in(16'hFFFF, 16'h0000, 16'hA5A5, 16'h5A5A, 2'(i));
        end
        chk("t4_z", {16'h0, OUT}, 32'h5A5A);
        rst_n = 1'b0; en = 1'b1;
        tick();
        chk("t5_rst_q", {16'h0, OUT_Q}, 32'd0);
        chk("t5_rst_v", {31'h0, VLD_Q}, 32'd0);
        rst_n = 1'b1;
        set_in(16'd1, 16'd2, 16'd3, 16'd24, 2'd3);
        tick();
        chk("t5_cap_q", {16'h0, OUT_Q}, 32'd24);
        chk("t5_cap_s", {30'h0, S_Q}, 32'd3);
        chk("t5_cap_v", {31'h0, VLD_Q}, 32'd1);
        en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            set_in(16'(100 + i), 16'(200 + i), 16'(300 + i), 16'(400 + i), 2'(i));
            tick();
        end
        chk("t6_hold_q", {16'h0, OUT_Q}, 32'd24);
        chk("t6_hold_s", {30'h0, S_Q}, 32'd3);
        chk("t6_follow", {16'h0, OUT}, 32'd302);
        rst_n = 1'b0; en = 1'b1;
        tick();
        chk("t6_clr_q", {16'h0, OUT_Q}, 32'd0);
        chk("t6_clr_v", {31'h0, VLD_Q}, 32'd0);
        for (int i = 0; i < 300; i++) begin
            rst_n = ($urandom_range(0, 15) != 0);
            en = 1'($urandom_range(0, 1));
            set_in(16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom), 2'($urandom_range(0, 3)));
            tick();
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
